alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, operand/result width; OPW, 4, ALU op-code width; ALU_LAT, 1, ALU clocks from registered inputs to valid result, legal range 0..7.
REQ-002 Ports SHALL be, in order:
  - clk  in  1  clock, rising edge.
  - rst  in  1  reset, asynchronous, active-low.
  - req0_valid  in  1  requester 0 has an op.
  - req0_ready  out  1  requester 0 op accepted this cycle.
  - req0_op  in  OPW  ALU op code (shared ALU_* defines).
  - req0_a, req0_b  in  WIDTH  operands.
  - req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
  - rsp0_valid  out  1  result for requester 0 available.
  - rsp0_ready  in  1  requester 0 takes result.
  - rsp0_data  out  WIDTH  result.
  - rsp1_valid, rsp1_ready, rsp1_data: same as response 0, for requester 1.
  - alu_op  out  OPW  to shared ALU op.
  - alu_a, alu_b  out  WIDTH  to shared ALU in_a/in_b.
  - alu_s  in  WIDTH  from shared ALU out_s.
  - busy  out  1  high in any state but IDLE.
  - grant_id  out  1  requester owning the current or last transaction.

Function
REQ-003 FSM SHALL have states IDLE, WAIT, RESP; one transaction in flight at a time.
REQ-004 IDLE, no valid: SHALL remain IDLE; all ready low.
REQ-005 IDLE, exactly one valid: SHALL grant that requester.
REQ-006 IDLE, both valid: SHALL grant the requester not equal to rr_last (round-robin).
REQ-007 reqN_ready SHALL be combinational, high only in IDLE for the granted requester; at most one ready high per cycle.
REQ-008 Accept edge (valid&&ready): SHALL register op/a/b onto alu_op/alu_a/alu_b, set grant_id and rr_last to N, load cnt=ALU_LAT, go WAIT.
REQ-009 Requester inputs SHALL be ignored outside the accept edge; later changes SHALL not affect the result.
REQ-010 WAIT: each edge with cnt!=0 SHALL decrement cnt; edge with cnt==0 SHALL capture alu_s into the result register and go RESP.
REQ-011 rspN_valid SHALL rise exactly ALU_LAT+1 clocks after the accept edge, only for N==grant_id.
REQ-012 RESP: rspN_valid and rspN_data SHALL hold stable until the edge where rspN_ready is high; that edge SHALL go IDLE and drop rspN_valid.
REQ-013 No new request SHALL be accepted in WAIT or RESP; throughput SHALL be at most one op per ALU_LAT+3 clocks.
REQ-014 rspN_ready high while rspN_valid is low SHALL have no effect.
REQ-015 rsp*_data of the non-granted requester SHALL read 0.
REQ-016 alu_op/alu_a/alu_b SHALL hold the last issued values while IDLE.

Reset
REQ-017 rst low SHALL immediately (asynchronously) force: state IDLE, cnt 0, rr_last 1, grant_id 0, alu_op/alu_a/alu_b 0, result 0, all rsp*_valid 0, busy 0.
REQ-018 A transaction in flight at reset SHALL be discarded with no response.
REQ-019 The first tie after reset SHALL be won by requester 0.

Verification
REQ-020 Req0 only, ALU_ADD a=0x10 b=0x20, ALU_LAT=1 -> accepted the same cycle; rsp0_valid exactly 2 clocks after accept; rsp0_data=0x00000030; rsp1_valid stays 0.
REQ-021 After reset, both valid the same cycle: req0 ALU_SUB 0x30,0x10; req1 ALU_ADD 0x5,0x5 -> req0 served first with 0x20, then req1 with 0xA; grant_id 0 then 1.
REQ-022 Both requesters held valid continuously for 4 transactions -> grant order 0,1,0,1; never two readys in one cycle.
REQ-023 rsp0_ready held low 5 clocks in RESP -> rsp0_valid=1 and rsp0_data=0x30 stable; req1_ready stays 0; req1 accepted the cycle after rsp0_ready handshake.
REQ-024 req0_a changed to 0xFFFFFFFF one clock after accept -> result still 0x30.
REQ-025 rst asserted during WAIT -> outputs at reset values without a clock edge; no response after release; next req0 accepted normally.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: round-robin grant, one op in
// flight, fixed ALU latency, and a held response until the owner takes it.
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 4,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_s,
  output logic             busy,
  output logic             grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] LAT_C = 3'(ALU_LAT);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [2:0]       cnt_r;
  logic             rr_last_r;
  logic             grant_r;
  logic             grant_nxt_s;
  logic             gnt_s;
  logic             gnt_vld_s;
  logic             accept_s;
  logic             capture_s;
  logic [OPW-1:0]   alu_op_r;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic [WIDTH-1:0] result_r;
  logic             rsp0_valid_r;
  logic             rsp1_valid_r;
  logic             busy_r;

  // Grant selection and next-state decode
  always_comb begin
    state_nxt_s = state_r;
    gnt_s       = 1'b0;
    gnt_vld_s   = 1'b0;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // On a tie the requester that did not win last time goes next
        if (req0_valid && req1_valid) begin
          gnt_vld_s = 1'b1;
          gnt_s     = ~rr_last_r;
        end else if (req0_valid) begin
          gnt_vld_s = 1'b1;
          gnt_s     = 1'b0;
        end else if (req1_valid) begin
          gnt_vld_s = 1'b1;
          gnt_s     = 1'b1;
        end else begin
          gnt_vld_s = 1'b0;
          gnt_s     = 1'b0;
        end
        if (gnt_vld_s) begin
          accept_s    = 1'b1;
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 3'd0) begin
          capture_s   = 1'b1;
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP: begin
        if ((grant_r == 1'b0) ? rsp0_ready : rsp1_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    grant_nxt_s = accept_s ? gnt_s : grant_r;
  end

  // State, ALU issue registers, latency counter and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= 3'd0;
      rr_last_r    <= 1'b1;
      grant_r      <= 1'b0;
      alu_op_r     <= '0;
      alu_a_r      <= '0;
      alu_b_r      <= '0;
      result_r     <= '0;
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      grant_r      <= grant_nxt_s;
      busy_r       <= (state_nxt_s != IDLE);
      rsp0_valid_r <= (state_nxt_s == RESP) && (grant_nxt_s == 1'b0);
      rsp1_valid_r <= (state_nxt_s == RESP) && (grant_nxt_s == 1'b1);
      if (accept_s) begin
        rr_last_r <= gnt_s;
        cnt_r     <= LAT_C;
        alu_op_r  <= gnt_s ? req1_op : req0_op;
        alu_a_r   <= gnt_s ? req1_a  : req0_a;
        alu_b_r   <= gnt_s ? req1_b  : req0_b;
      end else if ((state_r == WAIT) && (cnt_r != 3'd0)) begin
        cnt_r <= cnt_r - 3'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (capture_s) begin
        result_r <= alu_s;
      end else begin
        result_r <= result_r;
      end
    end
  end

  assign req0_ready = accept_s && (gnt_s == 1'b0);
  assign req1_ready = accept_s && (gnt_s == 1'b1);
  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  // Only the owning requester sees the result; the other side reads zero
  assign rsp0_data  = (grant_r == 1'b0) ? result_r : '0;
  assign rsp1_data  = (grant_r == 1'b1) ? result_r : '0;
  assign alu_op     = alu_op_r;
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign busy       = busy_r;
  assign grant_id   = grant_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a one-stage registered ALU model
// standing in for the shared ALU (ALU_LAT = 1).
module tb_alu_arbiter;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_s;
  logic        busy, grant_id;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.WIDTH(32), .OPW(4), .ALU_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model: one register stage after the issued operands
  always @(posedge clk) begin
    case (alu_op)
      ALU_ADD: alu_s <= alu_a + alu_b;
      ALU_SUB: alu_s <= alu_a - alu_b;
      ALU_AND: alu_s <= alu_a & alu_b;
      ALU_OR:  alu_s <= alu_a | alu_b;
      default: alu_s <= alu_a ^ alu_b;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int dbl;
    int seen_rsp;
    logic order [4];

    rst = 1'b0;
    req0_valid = 1'b0; req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset state
    #2;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk1("rst_grant", grant_id, 1'b0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk1("rst_idle_ready0", req0_ready, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // Single requester ADD; late operand change; rsp0_ready high before valid
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'h10; req0_b = 32'h20;
    #1;
    chk1("t1_ready0", req0_ready, 1'b1);
    chk1("t1_ready1", req1_ready, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0; req0_a = 32'hFFFF_FFFF; rsp0_ready = 1'b1;
    chk1("t1_busy", busy, 1'b1);
    chk("t1_alu_a", alu_a, 32'h10);
    chk("t1_alu_op", 32'(alu_op), 32'(ALU_ADD));
    chk1("t1_grant", grant_id, 1'b0);
    chk1("t1_valid_e0", rsp0_valid, 1'b0);
    @(negedge clk);
    chk1("t1_valid_e1", rsp0_valid, 1'b0);
    @(negedge clk);
    chk1("t1_valid_e2", rsp0_valid, 1'b1);
    chk("t1_data", rsp0_data, 32'h30);
    chk1("t1_rsp1_valid", rsp1_valid, 1'b0);
    chk("t1_rsp1_data", rsp1_data, 32'h0);
    @(negedge clk);
    rsp0_ready = 1'b0;
    chk1("t1_valid_drop", rsp0_valid, 1'b0);
    chk1("t1_idle", busy, 1'b0);
    chk("t1_alu_hold", alu_a, 32'h10);

    // Tie right after reset: req0 first, then req1
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = ALU_SUB; req0_a = 32'h30; req0_b = 32'h10;
    req1_valid = 1'b1; req1_op = ALU_ADD; req1_a = 32'h5;  req1_b = 32'h5;
    #1;
    chk1("t2_ready0", req0_ready, 1'b1);
    chk1("t2_ready1", req1_ready, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0;
    chk1("t2_grant0", grant_id, 1'b0);
    chk1("t2_wait_ready1", req1_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk1("t2_rsp0_valid", rsp0_valid, 1'b1);
    chk("t2_rsp0_data", rsp0_data, 32'h20);
    rsp0_ready = 1'b1;
    #1;
    chk1("t2_resp_ready1", req1_ready, 1'b0);
    @(negedge clk);
    rsp0_ready = 1'b0;
    chk1("t2_rsp0_drop", rsp0_valid, 1'b0);
    chk1("t2_ready1_after", req1_ready, 1'b1);
    @(negedge clk);
    req1_valid = 1'b0;
    chk1("t2_grant1", grant_id, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk1("t2_rsp1_valid", rsp1_valid, 1'b1);
    chk("t2_rsp1_data", rsp1_data, 32'hA);
    chk("t2_rsp0_zero", rsp0_data, 32'h0);
    rsp1_ready = 1'b1;
    @(negedge clk);
    rsp1_ready = 1'b0;
    chk1("t2_rsp1_drop", rsp1_valid, 1'b0);

    // Both held valid for four transactions: alternate 0,1,0,1
    req0_valid = 1'b1; req0_op = ALU_OR;  req0_a = 32'h1; req0_b = 32'h2;
    req1_valid = 1'b1; req1_op = ALU_AND; req1_a = 32'h3; req1_b = 32'h1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    n = 0; dbl = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      #1;
      if (req0_ready && req1_ready) dbl++;
      if (req0_ready) begin order[n] = 1'b0; n++; end
      else if (req1_ready) begin order[n] = 1'b1; n++; end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t3_count", 32'(n), 32'd4);
    chk("t3_double_ready", 32'(dbl), 32'd0);
    chk1("t3_order0", order[0], 1'b0);
    chk1("t3_order1", order[1], 1'b1);
    chk1("t3_order2", order[2], 1'b0);
    chk1("t3_order3", order[3], 1'b1);
    for (int c = 0; c < 10 && busy; c++) @(negedge clk);
    chk1("t3_idle", busy, 1'b0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Response held for five clocks while req1 waits
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'h10; req0_b = 32'h20;
    req1_valid = 1'b1; req1_op = ALU_ADD; req1_a = 32'h1;  req1_b = 32'h2;
    #1;
    chk1("t4_ready0", req0_ready, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      chk1("t4_hold_valid", rsp0_valid, 1'b1);
      chk("t4_hold_data", rsp0_data, 32'h30);
      chk1("t4_hold_ready1", req1_ready, 1'b0);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    rsp0_ready = 1'b0;
    chk1("t4_rsp0_drop", rsp0_valid, 1'b0);
    chk1("t4_ready1", req1_ready, 1'b1);
    @(negedge clk);
    req1_valid = 1'b0; rsp1_ready = 1'b1;
    chk1("t4_grant1", grant_id, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t4_rsp1_data", rsp1_data, 32'h3);
    @(negedge clk);
    rsp1_ready = 1'b0;
    chk1("t4_idle", busy, 1'b0);

    // Reset during WAIT discards the transaction
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'h1; req0_b = 32'h1;
    @(negedge clk);
    req0_valid = 1'b0; rsp0_ready = 1'b1;
    chk1("t5_in_wait", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_alu_a", alu_a, 32'h0);
    chk("t5_rst_alu_op", 32'(alu_op), 32'h0);
    chk1("t5_rst_grant", grant_id, 1'b0);
    chk1("t5_rst_rsp0", rsp0_valid, 1'b0);
    @(negedge clk); rst = 1'b1;
    seen_rsp = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) seen_rsp++;
    end
    chk("t5_no_rsp", 32'(seen_rsp), 32'd0);
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_a = 32'h10; req0_b = 32'h20;
    #1;
    chk1("t5_ready0", req0_ready, 1'b1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("t5_rsp0_valid", rsp0_valid, 1'b1);
    chk("t5_rsp0_data", rsp0_data, 32'h30);
    @(negedge clk);
    chk1("t5_done", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
